jtpopeye_objdma: RTL and testbench
==================================

Name: jtpopeye_objdma

Overview:
- Parametrised object-table DMA engine; successor of the fixed 4-bank, 1024-byte Popeye sprite DMA.
- On each trigger it requests the CPU bus and copies BANKS×2^AW bytes from main RAM into BANKS internal object-RAM banks.
- Optional double buffering: the renderer reads a stable front table while the next one fills.
- Sits between main CPU bus arbitration and the object renderer.

Parameters:
- AW, 8, object index width (2^AW entries per bank).
- BANKS, 4, number of object RAM banks (power of two, ≥2).
- DW, 8, bank data width (≤8; low DW bits of bus_din stored).
- DBUF, 1, 1 = double-buffered tables, 0 = single table written in place.
- TRIG, 0, 0 = trigger on vb rising edge, 1 = trigger on cpu_go pulse.

Ports:
- rst_n in 1: async reset, active-low.
- clk in 1: system clock.
- pxl_cen in 1: clock enable; all sequential logic except reset advances only when high.
- vb in 1: vertical blank.
- cpu_go in 1: one-cen start pulse, used when TRIG=1.
- busak_n in 1: bus acknowledge, active-low.
- bus_din in 8: main RAM read data.
- busrq_n out 1: bus request, active-low.
- bus_addr out AW+log2(BANKS): linear source address, {bank, index}.
- dma_cs out 1: main RAM read strobe.
- busy out 1: transfer in progress.
- swap out 1: one-cen pulse when a new table becomes visible.
- rd_addr in AW: renderer object index.
- obj_dout out BANKS*DW: bank b on bits [b*DW +: DW], registered, 1-cen latency from rd_addr.

Behaviour:
- Reset values:
  - Outputs: busrq_n=1, dma_cs=0, busy=0, swap=0, bus_addr=0.
  - State and buffers: FSM=IDLE, counter=0, front buffer select=0.
  - RAM contents undefined.
- FSM states, transitions evaluated on pxl_cen:
  - IDLE → REQ on trigger (vb 0→1 edge, or cpu_go when TRIG=1). busrq_n←0, busy←1, counter←0.
  - REQ → ADDR when busak_n=0.
  - ADDR: bus_addr←counter, dma_cs←1 → DATA.
  - DATA: write bus_din[DW-1:0] into bank counter[top bits] at index counter[AW-1:0] (back buffer if DBUF). dma_cs←0.
    - If counter = BANKS*2^AW-1 → DONE.
    - Otherwise counter+1 → ADDR.
  - DONE: busrq_n←1, busy←0. If DBUF, toggle front select and pulse swap; if DBUF=0, pulse swap only. → IDLE.
- Throughput: one byte per 2 enabled cycles. Total = 2·BANKS·2^AW + grant wait + 2 cens (2048 data cens for defaults).
- Counter: width AW+log2(BANKS), bank-major order. Terminal detection is by compare, not wrap; the counter never wraps into a second pass.
- Grant loss: if busak_n=1 in ADDR or DATA, freeze.
  - dma_cs←0, no RAM write, counter held, busrq_n stays 0.
  - Resume at the same address in ADDR once busak_n=0 again. No byte is skipped or duplicated.
- Triggers while busy are ignored; no queuing.
- vb falling before completion does not abort; the transfer runs to the end.
- Renderer reads:
  - DBUF=1: rd_addr always reads the front buffer. A swap takes effect on the read issued the cen after the swap pulse.
  - DBUF=0: reads hit the live table; tearing is accepted.
- Simultaneous trigger and DONE in the same cen: the trigger is ignored.
- Async reset mid-transfer: immediate return to reset values and busrq_n=1. The partial back buffer is never swapped in.
- No state advances without pxl_cen; a pxl_cen tied high is legal.

Test Plan:
- Default params, RAM byte k = k^0x5A, vb edge, busak_n=0 after 3 cens:
  - swap once after 2048+5 cens.
  - Then reading rd_addr=0x10 gives obj_dout = {0x5A^0x310, 0x5A^0x210, 0x5A^0x110, 0x5A^0x010}, each truncated to 8 bits.
- busak_n forced high for 7 cens at counter 0x1FF:
  - dma_cs=0 throughout the stall.
  - Address 0x1FF is read exactly once.
  - Final table matches a stall-free run.
- DBUF=1, fill table A, then start a second transfer with new data:
  - rd_addr=5 returns table A values until the swap pulse, table B values on the next read.
- Second vb edge and cpu_go while busy:
  - exactly one swap.
  - busrq_n goes low once.
- rst_n low at counter 0x080:
  - busrq_n=1, busy=0 immediately.
  - After release, front buffer unchanged and no swap until a new full transfer.
- AW=6, BANKS=2, DW=5, TRIG=1, cpu_go pulse:
  - 128 bytes copied.
  - bus_addr max 0x7F.
  - Only bits [4:0] stored.
  - vb edges ignored.

Source files
------------

// File: rtl/jtpopeye_objdma.sv
// Object-table DMA: copies BANKS x 2^AW bytes from main RAM into banked object RAM on each trigger.
// One byte per two enabled cycles; renderer read port has 1-cen latency from rd_addr.
// Stalls in place while bus grant is withdrawn; triggers while busy are dropped.
module jtpopeye_objdma #(
    parameter int AW    = 8,
    parameter int BANKS = 4,
    parameter int DW    = 8,
    parameter int DBUF  = 1,
    parameter int TRIG  = 0
) (
    input  logic                          rst_n,
    input  logic                          clk,
    input  logic                          pxl_cen,
    input  logic                          vb,
    input  logic                          cpu_go,
    input  logic                          busak_n,
    input  logic [7:0]                    bus_din,
    output logic                          busrq_n,
    output logic [AW+$clog2(BANKS)-1:0]   bus_addr,
    output logic                          dma_cs,
    output logic                          busy,
    output logic                          swap,
    input  logic [AW-1:0]                 rd_addr,
    output logic [BANKS*DW-1:0]           obj_dout
);

    localparam int BW = $clog2(BANKS);
    localparam int CW = AW + BW;
    localparam logic [CW-1:0] LAST = '1;

    typedef enum logic [2:0] {IDLE, REQ, ADDR, DATA, DONE} state_t;

    state_t        state, st_nx;
    logic [CW-1:0] cnt, cnt_nx, addr_nx;
    logic          vb_l, trig;
    logic          front, front_nx;
    logic          dma_q, dma_nx;
    logic          busrq_nx, busy_nx, swap_nx;
    logic          we;
    logic [AW:0]   waddr, raddr;

    assign trig   = (TRIG != 0) ? cpu_go : (vb & ~vb_l);
    // Strobe drops the moment the grant goes away, not one cen later.
    assign dma_cs = dma_q & ~busak_n;
    assign waddr  = {(DBUF != 0) & ~front, cnt[AW-1:0]};
    assign raddr  = {(DBUF != 0) & front, rd_addr};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else if (pxl_cen)
            state <= st_nx;
    end

    always_comb begin
        st_nx = state;
        unique case (state)
            IDLE:    if (trig) st_nx = REQ;
            REQ:     if (!busak_n) st_nx = ADDR;
            ADDR:    if (!busak_n) st_nx = DATA;
            DATA: begin
                if (busak_n)
                    st_nx = ADDR;
                else if (cnt == LAST)
                    st_nx = DONE;
                else
                    st_nx = ADDR;
            end
            DONE:    st_nx = IDLE;
            default: st_nx = IDLE;
        endcase
    end

    always_comb begin
        busrq_nx = busrq_n;
        busy_nx  = busy;
        cnt_nx   = cnt;
        addr_nx  = bus_addr;
        dma_nx   = 1'b0;
        swap_nx  = 1'b0;
        front_nx = front;
        we       = 1'b0;
        unique case (state)
            IDLE: begin
                if (trig) begin
                    busrq_nx = 1'b0;
                    busy_nx  = 1'b1;
                    cnt_nx   = '0;
                end
            end
            ADDR: begin
                if (!busak_n) begin
                    addr_nx = cnt;
                    dma_nx  = 1'b1;
                end
            end
            DATA: begin
                // A lost grant leaves cnt untouched so the same byte is re-read.
                if (!busak_n) begin
                    we = 1'b1;
                    if (cnt != LAST)
                        cnt_nx = cnt + CW'(1);
                end
            end
            DONE: begin
                busrq_nx = 1'b1;
                busy_nx  = 1'b0;
                swap_nx  = 1'b1;
                front_nx = (DBUF != 0) ? ~front : front;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            bus_addr <= '0;
            busrq_n  <= 1'b1;
            dma_q    <= 1'b0;
            busy     <= 1'b0;
            swap     <= 1'b0;
            front    <= 1'b0;
            vb_l     <= 1'b0;
        end else if (pxl_cen) begin
            cnt      <= cnt_nx;
            bus_addr <= addr_nx;
            busrq_n  <= busrq_nx;
            dma_q    <= dma_nx;
            busy     <= busy_nx;
            swap     <= swap_nx;
            front    <= front_nx;
            vb_l     <= vb;
        end
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        logic [DW-1:0] mem [0:(2**(AW+1))-1];
        logic [DW-1:0] rd_q;
        logic          bank_we;

        assign bank_we = we & (cnt[CW-1:AW] == BW'(b));

        always_ff @(posedge clk) begin
            if (pxl_cen && bank_we)
                mem[waddr] <= bus_din[DW-1:0];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                rd_q <= '0;
            else if (pxl_cen)
                rd_q <= mem[raddr];
        end

        assign obj_dout[b*DW +: DW] = rd_q;
    end

    if (DW < 8) begin : g_unused
        logic unused_hi;
        assign unused_hi = ^bus_din[7:DW];
    end

endmodule

// File: tb/tb_jtpopeye_objdma.sv
// Bench for jtpopeye_objdma: default instance plus a small TRIG=1 instance sharing one RAM model.
module tb_jtpopeye_objdma;

    logic        clk = 1'b0, rst_n = 1'b0, pxl_cen = 1'b0;
    logic        vb = 1'b0, cpu_go = 1'b0, cpu_go2 = 1'b0;
    logic        busak_n = 1'b1, busak2_n = 1'b1;
    logic [7:0]  bus_din, bus_din2;
    logic        busrq_n, busrq2_n, dma_cs, dma_cs2, busy, busy2, swap, swap2;
    logic [9:0]  bus_addr;
    logic [6:0]  bus_addr2;
    logic [7:0]  rd_addr = 8'd0;
    logic [31:0] obj_dout;
    logic [9:0]  obj_dout2;

    logic [7:0]  ram [0:1023];
    int          front1 [0:1023];
    int          front2 [0:127];

    int          n_cmp = 0, n_err = 0;
    int          exp_addr1[$], exp_addr2[$];
    int          exp_swap1 = 0, exp_swap2 = 0;
    int          falls1 = 0, falls2 = 0, exp_falls1 = 0, exp_falls2 = 0;
    logic        busrq_l = 1'b1, busrq2_l = 1'b1;
    logic [31:0] exp_rd[$];
    logic        rd_vld = 1'b0, rd_sel = 1'b0, pend = 1'b0, pend_sel = 1'b0;

    assign bus_din  = ram[bus_addr];
    assign bus_din2 = ram[{3'b000, bus_addr2}];

    jtpopeye_objdma u_dut (
        .rst_n(rst_n), .clk(clk), .pxl_cen(pxl_cen), .vb(vb), .cpu_go(cpu_go),
        .busak_n(busak_n), .bus_din(bus_din), .busrq_n(busrq_n), .bus_addr(bus_addr),
        .dma_cs(dma_cs), .busy(busy), .swap(swap), .rd_addr(rd_addr), .obj_dout(obj_dout)
    );

    jtpopeye_objdma #(.AW(6), .BANKS(2), .DW(5), .DBUF(1), .TRIG(1)) u_dut2 (
        .rst_n(rst_n), .clk(clk), .pxl_cen(pxl_cen), .vb(vb), .cpu_go(cpu_go2),
        .busak_n(busak2_n), .bus_din(bus_din2), .busrq_n(busrq2_n), .bus_addr(bus_addr2),
        .dma_cs(dma_cs2), .busy(busy2), .swap(swap2), .rd_addr(rd_addr[5:0]), .obj_dout(obj_dout2)
    );

    always #5 clk = ~clk;

    // Random clock enable, changed just after each rising edge.
    always @(posedge clk) begin
        #1;
        pxl_cen = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Monitor: samples at the falling edge what the next rising edge will act on.
    always @(negedge clk) begin
        if (pend) begin
            pend = 1'b0;
            if (exp_rd.size() == 0)
                chk("rd_queue_empty", 32'd1, 32'd0);
            else if (pend_sel)
                chk("obj_dout2", {22'd0, obj_dout2}, exp_rd.pop_front());
            else
                chk("obj_dout", obj_dout, exp_rd.pop_front());
        end
        if (pxl_cen) begin
            if (rd_vld) begin
                pend     = 1'b1;
                pend_sel = rd_sel;
            end
            if (dma_cs) begin
                if (exp_addr1.size() == 0) chk("addr1_unexpected", {22'd0, bus_addr}, 32'hFFFF);
                else chk("bus_addr", {22'd0, bus_addr}, exp_addr1.pop_front());
            end
            if (dma_cs2) begin
                if (exp_addr2.size() == 0) chk("addr2_unexpected", {25'd0, bus_addr2}, 32'hFFFF);
                else chk("bus_addr2", {25'd0, bus_addr2}, exp_addr2.pop_front());
            end
            if (swap) begin
                n_cmp++;
                if (exp_swap1 > 0) exp_swap1--;
                else begin n_err++; $display("FAIL swap1 unexpected got=1 exp=0"); end
            end
            if (swap2) begin
                n_cmp++;
                if (exp_swap2 > 0) exp_swap2--;
                else begin n_err++; $display("FAIL swap2 unexpected got=1 exp=0"); end
            end
        end
        if (busak_n && busy) chk("dma_cs_no_grant", {31'd0, dma_cs}, 32'd0);
        if (busrq_l && !busrq_n) falls1++;
        if (busrq2_l && !busrq2_n) falls2++;
        busrq_l  = busrq_n;
        busrq2_l = busrq2_n;
    end

    task automatic cen_step();
        bit c;
        c = 1'b0;
        while (!c) begin
            @(posedge clk);
            c = pxl_cen;
        end
        #2;
    endtask

    task automatic cens(input int n);
        repeat (n) cen_step();
    endtask

    task automatic fill(input bit rnd);
        for (int k = 0; k < 1024; k++)
            ram[k] = rnd ? 8'($urandom) : 8'(k ^ 'h5A);
    endtask

    task automatic rd1(input int a);
        exp_rd.push_back({front1[768+a][7:0], front1[512+a][7:0], front1[256+a][7:0], front1[a][7:0]});
        rd_addr = 8'(a);
        rd_sel  = 1'b0;
        rd_vld  = 1'b1;
        cen_step();
        rd_vld  = 1'b0;
    endtask

    task automatic rd2(input int a);
        exp_rd.push_back({22'd0, front2[64+a][4:0], front2[a][4:0]});
        rd_addr = 8'(a);
        rd_sel  = 1'b1;
        rd_vld  = 1'b1;
        cen_step();
        rd_vld  = 1'b0;
    endtask

    task automatic xfer1(input bit stall, input bit extra, input int abort_at, input bit rd5);
        int t;
        bit stalled, done;
        for (int k = 0; k < 1024; k++) exp_addr1.push_back(k);
        exp_falls1++;
        if (abort_at < 0) exp_swap1++;
        vb = 1'b0; cen_step();
        vb = 1'b1; cen_step();
        t = 0;
        while (busrq_n && t < 50) begin cen_step(); t++; end
        chk("busrq_n_low", {31'd0, busrq_n}, 32'd0);
        cens(3);
        busak_n = 1'b0;
        t = 0; stalled = 1'b0; done = 1'b0;
        while (busy && t < 6000 && !done) begin
            if (rd5) rd1(5);
            else cen_step();
            t++;
            if (stall && !stalled && dma_cs && bus_addr == 10'h1FF) begin
                busak_n = 1'b1;
                cens(7);
                busak_n = 1'b0;
                stalled = 1'b1;
            end
            if (extra && t == 100) begin
                vb = 1'b0; cen_step();
                vb = 1'b1; cpu_go = 1'b1; cen_step();
                cpu_go = 1'b0;
            end
            if (abort_at >= 0 && dma_cs && bus_addr == 10'(abort_at)) begin
                rst_n = 1'b0;
                #1;
                chk("abort_busrq_n", {31'd0, busrq_n}, 32'd1);
                chk("abort_busy", {31'd0, busy}, 32'd0);
                chk("abort_dma_cs", {31'd0, dma_cs}, 32'd0);
                chk("abort_swap", {31'd0, swap}, 32'd0);
                exp_addr1.delete();
                repeat (2) @(posedge clk);
                #2;
                rst_n = 1'b1;
                done = 1'b1;
            end
        end
        if (abort_at < 0) chk("xfer1_finished", {31'd0, busy}, 32'd0);
        if (stall) chk("stall_seen", {31'd0, stalled}, 32'd1);
        busak_n = 1'b1;
        vb = 1'b0;
        if (abort_at < 0)
            for (int k = 0; k < 1024; k++) front1[k] = int'(ram[k]);
        cen_step();
    endtask

    task automatic xfer2();
        int t;
        for (int k = 0; k < 128; k++) exp_addr2.push_back(k);
        exp_falls2++;
        exp_swap2++;
        cpu_go2 = 1'b1; cen_step();
        cpu_go2 = 1'b0;
        t = 0;
        while (busrq2_n && t < 50) begin cen_step(); t++; end
        chk("busrq2_n_low", {31'd0, busrq2_n}, 32'd0);
        cens(3);
        busak2_n = 1'b0;
        t = 0;
        while (busy2 && t < 1000) begin cen_step(); t++; end
        chk("xfer2_finished", {31'd0, busy2}, 32'd0);
        busak2_n = 1'b1;
        for (int k = 0; k < 128; k++) front2[k] = int'(ram[k]);
        cen_step();
    endtask

    initial begin
        for (int k = 0; k < 1024; k++) ram[k] = 8'd0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_busrq_n", {31'd0, busrq_n}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_dma_cs", {31'd0, dma_cs}, 32'd0);
        chk("rst_swap", {31'd0, swap}, 32'd0);
        chk("rst_bus_addr", {22'd0, bus_addr}, 32'd0);
        chk("rst_busrq2_n", {31'd0, busrq2_n}, 32'd1);
        rst_n = 1'b1;
        cens(4);

        // Pattern k^0x5A, plain run.
        fill(1'b0);
        xfer1(1'b0, 1'b0, -1, 1'b0);
        rd1('h10);
        repeat (6) rd1($urandom_range(0, 255));

        // New data, grant stall at 0x1FF, extra triggers while busy, reads across the swap.
        fill(1'b1);
        xfer1(1'b1, 1'b1, -1, 1'b1);
        rd1(5);
        repeat (6) rd1($urandom_range(0, 255));

        // Reset in the middle; front table must survive and no swap may follow.
        fill(1'b1);
        xfer1(1'b0, 1'b0, 'h080, 1'b0);
        cens(30);
        repeat (6) rd1($urandom_range(0, 255));

        fill(1'b1);
        xfer1(1'b0, 1'b0, -1, 1'b0);
        repeat (6) rd1($urandom_range(0, 255));

        // Small instance: cpu_go trigger, 5-bit data.
        fill(1'b1);
        xfer2();
        rd2(0);
        rd2(63);
        repeat (6) rd2($urandom_range(0, 63));

        cens(10);
        chk("addr1_left", exp_addr1.size(), 32'd0);
        chk("addr2_left", exp_addr2.size(), 32'd0);
        chk("swap1_left", exp_swap1, 32'd0);
        chk("swap2_left", exp_swap2, 32'd0);
        chk("busrq1_falls", falls1, exp_falls1);
        chk("busrq2_falls", falls2, exp_falls2);
        chk("rd_left", exp_rd.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
